// File: rtl/uart_chan_arbiter.sv
// Multi-channel UART TX pump: per-channel byte FIFOs, round-robin arbitration,
// optional SYNC / channel-id / data framing toward a single UART_TX.
module uart_chan_arbiter #(
  parameter int         NUM_CH     = 8,
  parameter int         FIFO_DEPTH = 32,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FRAME_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_valid_i,
  input  logic [NUM_CH*8-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]     ch_full_o,
  output logic [NUM_CH-1:0]     ovf_o,
  input  logic [NUM_CH-1:0]     ovf_clr_i,
  output logic                  uart_tx_en_o,
  output logic [7:0]            uart_tx_data_o,
  input  logic                  uart_tx_busy_i,
  output logic                  busy_o
);

  // state     | meaning
  // S_IDLE    | pick next non-empty channel, strobe its FIFO read
  // S_POP     | FIFO read data in flight
  // S_LATCH   | capture popped byte
  // S_TX_SYNC | send SYNC_BYTE when UART free
  // S_TX_CH   | send channel id when UART free
  // S_TX_DATA | send data byte, record last grant
  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LATCH, S_TX_SYNC, S_TX_CH, S_TX_DATA
  } state_t;

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  state_t            state, state_next;
  logic [NUM_CH-1:0] empty, full, wr_en, rd_en, ovf_set;
  logic [7:0]        rd_data [NUM_CH];
  logic [CW-1:0]     grant, last_grant, pick;
  logic              pick_found, rd_strobe, fire, holdoff, tx_ok;
  logic [7:0]        tx_byte, data_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic [7:0]    rd_q;

    // full is taken from the registered count, so a same-cycle pop never frees a slot
    assign full[k]    = (count == NW'(FIFO_DEPTH));
    assign empty[k]   = (count == '0);
    assign wr_en[k]   = ch_valid_i[k] & ~full[k];
    assign rd_en[k]   = rd_strobe & (pick == CW'(k));
    assign ovf_set[k] = ch_valid_i[k] & full[k];
    assign rd_data[k] = rd_q;

    always_ff @(posedge clk) begin
      if (wr_en[k]) mem[wr_ptr] <= ch_data_i[8*k +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        rd_q   <= '0;
      end else begin
        if (wr_en[k]) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en[k]) begin
          rd_ptr <= rd_ptr + 1'b1;
          rd_q   <= mem[rd_ptr];
        end
        case ({wr_en[k], rd_en[k]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign ch_full_o = full;

  // round-robin: the lowest offset from last_grant+1 wins
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!empty[CW'(idx)]) begin
        pick       = CW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  assign tx_ok = ~uart_tx_busy_i & ~holdoff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_strobe  = 1'b0;
    fire       = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          rd_strobe  = 1'b1;
          state_next = S_POP;
        end
      end
      S_POP:   state_next = S_LATCH;
      S_LATCH: state_next = (FRAME_MODE != 0) ? S_TX_SYNC : S_TX_DATA;
      S_TX_SYNC: begin
        tx_byte = SYNC_BYTE;
        if (tx_ok) begin
          fire       = 1'b1;
          state_next = S_TX_CH;
        end
      end
      S_TX_CH: begin
        tx_byte = 8'(grant);
        if (tx_ok) begin
          fire       = 1'b1;
          state_next = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        tx_byte = data_q;
        if (tx_ok) begin
          fire       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant          <= '0;
      last_grant     <= CW'(NUM_CH - 1);
      data_q         <= '0;
      holdoff        <= 1'b0;
      uart_tx_en_o   <= 1'b0;
      uart_tx_data_o <= '0;
      ovf_o          <= '0;
      busy_o         <= 1'b0;
    end else begin
      uart_tx_en_o <= fire;
      // UART_TX raises busy one cycle late; ignore busy for the cycle after a pulse
      holdoff      <= fire;
      if (fire) uart_tx_data_o <= tx_byte;
      if (rd_strobe) grant <= pick;
      if (state == S_LATCH) data_q <= rd_data[grant];
      if (fire && state == S_TX_DATA) last_grant <= grant;
      ovf_o  <= ovf_set | (ovf_o & ~ovf_clr_i);
      busy_o <= (state != S_IDLE) | ~(&empty);
    end
  end

endmodule

// File: tb/tb_uart_chan_arbiter.sv
// Scoreboard bench for uart_chan_arbiter: framed instance (depth 4) and raw instance.
module tb_uart_chan_arbiter;
  localparam int NCH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ch_valid, ch_full, ovf, ovf_clr;
  logic [NCH*8-1:0] ch_data;
  logic             tx_en, tx_busy, busy, hold_busy;
  logic [7:0]       tx_data;
  logic             en_d = 1'b0;

  logic [NCH-1:0]   r_valid, r_full, r_ovf, r_clr;
  logic [NCH*8-1:0] r_data;
  logic             r_en, r_busy_in, r_busy;
  logic [7:0]       r_txd;
  logic             r_en_d = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] raw_q[$];
  int checks = 0, failures = 0, cyc = 0, en_cnt = 0;
  int last_en = -10, r_last_en = -10;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART_TX stand-in: busy echoes the en pulse one cycle later, plus a forced hold
  always @(posedge clk) en_d <= tx_en;
  always @(posedge clk) r_en_d <= r_en;
  assign tx_busy   = hold_busy | en_d;
  assign r_busy_in = r_en_d;

  uart_chan_arbiter #(.NUM_CH(NCH), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5), .FRAME_MODE(1)) dut (
    .clk(clk), .rst(rst), .ch_valid_i(ch_valid), .ch_data_i(ch_data),
    .ch_full_o(ch_full), .ovf_o(ovf), .ovf_clr_i(ovf_clr),
    .uart_tx_en_o(tx_en), .uart_tx_data_o(tx_data),
    .uart_tx_busy_i(tx_busy), .busy_o(busy));

  uart_chan_arbiter #(.NUM_CH(NCH), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5), .FRAME_MODE(0)) dut_raw (
    .clk(clk), .rst(rst), .ch_valid_i(r_valid), .ch_data_i(r_data),
    .ch_full_o(r_full), .ovf_o(r_ovf), .ovf_clr_i(r_clr),
    .uart_tx_en_o(r_en), .uart_tx_data_o(r_txd),
    .uart_tx_busy_i(r_busy_in), .busy_o(r_busy));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && tx_en === 1'b1) begin
      en_cnt++;
      check("en_spacing", 32'(cyc - last_en >= 2), 1);
      last_en = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_en: got byte %0h expected no pulse", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && r_en === 1'b1) begin
      check("raw_en_spacing", 32'(cyc - r_last_en >= 2), 1);
      r_last_en = cyc;
      if (raw_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL raw_unexpected_en: got byte %0h expected no pulse", r_txd);
      end else begin
        check("raw_tx_byte", 32'(r_txd), 32'(raw_q.pop_front()));
      end
    end
  end

  task automatic push_frame(input int ch, input logic [7:0] b);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(ch));
    exp_q.push_back(b);
  endtask

  task automatic wait_en(input bit raw, input int max, output int at);
    at = -1;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if ((raw ? r_en : tx_en) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic drain(input string nm, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || raw_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain_left"}, 32'(exp_q.size() + raw_q.size()), 0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout: got time %0t expected earlier finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t0, t, snap, bad;
    logic [7:0] held;
    rst = 1'b1; ch_valid = '0; ch_data = '0; ovf_clr = '0; hold_busy = 1'b0;
    r_valid = '0; r_data = '0; r_clr = '0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(tx_en), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_full", 32'(ch_full), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // single byte on ch2, latency from write edge to first en
    @(negedge clk);
    push_frame(2, 8'h3C);
    ch_valid[2] = 1'b1; ch_data[23:16] = 8'h3C;
    @(negedge clk);
    t0 = cyc; ch_valid = '0;
    wait_en(1'b0, 20, t);
    check("t1_latency", 32'(t - t0), 4);
    drain("t1", 100);
    repeat (4) @(negedge clk);
    check("t1_busy_idle", 32'(busy), 0);

    // round robin across ch0/3/7 after reset
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    push_frame(0, 8'h01); push_frame(3, 8'h31); push_frame(7, 8'h71);
    push_frame(0, 8'h02); push_frame(3, 8'h32); push_frame(7, 8'h72);
    ch_valid = 8'b1000_1001;
    ch_data[7:0] = 8'h01; ch_data[31:24] = 8'h31; ch_data[63:56] = 8'h71;
    @(negedge clk);
    ch_data[7:0] = 8'h02; ch_data[31:24] = 8'h32; ch_data[63:56] = 8'h72;
    @(negedge clk);
    ch_valid = '0;
    drain("t2", 300);

    // overflow on ch1 while the FSM is parked on a ch2 frame
    hold_busy = 1'b1;
    push_frame(2, 8'h2B);
    ch_valid[2] = 1'b1; ch_data[23:16] = 8'h2B;
    @(negedge clk);
    ch_valid = '0;
    repeat (6) @(negedge clk);
    snap = en_cnt;
    for (int i = 0; i < 6; i++) begin
      ch_valid = '0; ch_valid[1] = 1'b1; ch_data[15:8] = 8'(8'h10 + i);
      if (i < 4) push_frame(1, 8'(8'h10 + i));
      @(negedge clk);
      if (i == 2) check("t3_full_after3", 32'(ch_full[1]), 0);
      if (i == 3) check("t3_full_after4", 32'(ch_full[1]), 1);
    end
    ch_valid = '0;
    @(negedge clk);
    check("t3_ovf1", 32'(ovf[1]), 1);
    check("t3_ovf_others", 32'(ovf & 8'hFD), 0);
    check("t3_no_en_hold", 32'(en_cnt - snap), 0);
    hold_busy = 1'b0;
    drain("t3", 400);
    check("t3_ovf_sticky", 32'(ovf[1]), 1);
    ovf_clr = 8'h02;
    @(negedge clk);
    ovf_clr = '0;
    check("t3_ovf_clr", 32'(ovf[1]), 0);

    // long busy hold after SYNC
    push_frame(4, 8'h4D);
    ch_valid[4] = 1'b1; ch_data[39:32] = 8'h4D;
    @(negedge clk);
    ch_valid = '0;
    wait_en(1'b0, 20, t);
    check("t4_sync_seen", 32'(t >= 0), 1);
    #1;
    hold_busy = 1'b1;
    snap = en_cnt; held = tx_data; bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_data !== held) bad++;
    end
    check("t4_no_en", 32'(en_cnt - snap), 0);
    check("t4_data_stable", 32'(bad), 0);
    check("t4_held_byte", 32'(held), 32'h A5);
    hold_busy = 1'b0;
    drain("t4", 100);

    // raw mode on the second instance
    raw_q.push_back(8'h11); raw_q.push_back(8'h22);
    r_valid[5] = 1'b1; r_data[47:40] = 8'h11;
    @(negedge clk);
    t0 = cyc; r_data[47:40] = 8'h22;
    @(negedge clk);
    r_valid = '0;
    wait_en(1'b1, 20, t);
    check("t5_raw_latency", 32'(t - t0), 4);
    drain("t5", 100);

    // async reset while waiting in TX_CH
    push_frame(6, 8'h99);
    ch_valid[6] = 1'b1; ch_data[55:48] = 8'h99;
    @(negedge clk);
    ch_valid = '0;
    wait_en(1'b0, 20, t);
    #1;
    hold_busy = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("t6_busy_before", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_en", 32'(tx_en), 0);
    check("t6_rst_data", 32'(tx_data), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_full", 32'(ch_full), 0);
    @(negedge clk);
    rst = 1'b0; hold_busy = 1'b0;
    repeat (8) @(negedge clk);
    push_frame(1, 8'h5A);
    ch_valid[1] = 1'b1; ch_data[15:8] = 8'h5A;
    @(negedge clk);
    ch_valid = '0;
    drain("t6", 100);
    repeat (4) @(negedge clk);
    check("t6_busy_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
